// File: rtl/phy_tx_scheduler.sv
// Purpose: holds the PHY_TX lane in a training window, then round-robins two requesters onto data_in/valid_in.
// Latency: one clk_f cycle from an accepted word (reqN_valid & reqN_ready) to data_out/valid_out.
// Backpressure: at most one reqN_ready per cycle; none during training or on a retrain pulse; burst capped at BURST_MAX.
//
// Ports:
//   clk_f, reset        word clock, asynchronous active-high reset
//   retrain             single-cycle pulse, re-enters the training window
//   reqN_valid/_data    requester N word offer (N = 0, 1); valid must not depend on ready
//   reqN_ready          requester N word accepted this cycle
//   data_out/valid_out  registered word to PHY_TX data_in/valid_in
//   training            registered, high while the lane is training
//   words_sent          registered count of forwarded words, wraps
`timescale 1ns/1ps
module phy_tx_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int TRAIN_CYCLES = 16,
  parameter int BURST_MAX    = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_f,
  input  logic                  reset,
  input  logic                  retrain,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  training,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int TW = $clog2(TRAIN_CYCLES + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_CYCLES - 1);
  localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

  typedef enum logic {TRAIN, RUN} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   train_cnt_q, train_cnt_d;
  logic            owner_q, owner_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            sel_vld;
  logic            sel_idx;
  logic            cur_vld, oth_vld;
  logic [DATA_WIDTH-1:0] sel_dat;

  // cur is the requester currently holding the burst, oth the one waiting.
  assign cur_vld = owner_q ? req1_valid : req0_valid;
  assign oth_vld = owner_q ? req0_valid : req1_valid;

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    sel_vld     = 1'b0;
    sel_idx     = owner_q;
    if (retrain) begin
      state_d     = TRAIN;
      train_cnt_d = '0;
      burst_cnt_d = '0;
    end else begin
      case (state_q)
        TRAIN: begin
          if (train_cnt_q == TRAIN_LAST) begin
            state_d     = RUN;
            train_cnt_d = '0;
          end else begin
            train_cnt_d = train_cnt_q + TW'(1);
          end
        end
        RUN: begin
          // The owner keeps the lane until its burst is used up, unless nobody else wants it.
          if (cur_vld && ((burst_cnt_q < BURST_TOP) || !oth_vld)) begin
            sel_vld = 1'b1;
            sel_idx = owner_q;
          end else if (oth_vld) begin
            sel_vld = 1'b1;
            sel_idx = ~owner_q;
          end
          if (sel_vld) begin
            if (sel_idx == owner_q) begin
              burst_cnt_d = (burst_cnt_q == BURST_TOP) ? BURST_TOP : burst_cnt_q + BW'(1);
            end else begin
              owner_d     = sel_idx;
              burst_cnt_d = BW'(1);
            end
          end else begin
            // An idle cycle ends the burst; owner is kept so round-robin order survives.
            burst_cnt_d = '0;
          end
        end
        default: state_d = TRAIN;
      endcase
    end
  end

  assign req0_ready = sel_vld & ~sel_idx;
  assign req1_ready = sel_vld &  sel_idx;
  assign sel_dat    = sel_idx ? req1_data : req0_data;

  // Owner resets to requester 0 so requester 0 takes the first grant after reset.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q     <= TRAIN;
      train_cnt_q <= '0;
      owner_q     <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      training   <= 1'b1;
      data_out   <= '0;
      valid_out  <= 1'b0;
      words_sent <= '0;
    end else begin
      training <= (state_d == TRAIN);
      if (retrain || (state_q == TRAIN)) begin
        // Zero data while training so PHY_TX sees a clean idle bus.
        data_out  <= '0;
        valid_out <= 1'b0;
      end else if (sel_vld) begin
        data_out   <= sel_dat;
        valid_out  <= 1'b1;
        words_sent <= words_sent + CNT_WIDTH'(1);
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
